error_sampler: RTL and testbench

ERROR_SAMPLER -- requirements
Module: error_sampler

---
 rtl/error_sampler.sv | 127 ++++++++++++
 tb/tb_error_sampler.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/error_sampler.sv
// error_sampler: samples a plant measurement on a programmable hold
// period, optionally smooths it with a 4-tap moving average, and produces
// a saturated 6-bit two's-complement error (setpoint - measurement) that
// is held constant between captures for the downstream multiplier.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   ena           clock enable; all state holds while low
//   setpoint      unsigned target value
//   measured      unsigned plant measurement
//   filt_en       1: use 4-tap moving average, 0: use raw sample
//   period        hold length minus 1 (each e held period+1 enabled cycles)
//   e             registered saturated error, two's complement
//   sample_strobe one-cycle pulse in the cycle e takes a new value
`timescale 1ns/1ps

module error_sampler (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [5:0] setpoint,
  input  logic [5:0] measured,
  input  logic       filt_en,
  input  logic [5:0] period,
  output logic [5:0] e,
  output logic       sample_strobe
);

  localparam int unsigned W    = 6;
  localparam int unsigned DW   = W + 1;
  localparam int unsigned SUMW = 8;
  localparam int unsigned NTAP = 4;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRIME = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]                state, state_nxt;
  logic [W-1:0]              cnt, cnt_nxt;
  logic [NTAP-1:0][W-1:0]    taps, taps_nxt;
  logic [W-1:0]              e_nxt;
  logic                      strobe_nxt;

  logic                      capture;
  logic [SUMW-1:0]           sum;
  logic [W-1:0]              avg;
  logic [W-1:0]              m;
  logic signed [DW-1:0]      d;

  // Next-state and datapath: capture happens on the PRIME edge and on
  // every RUN edge whose hold counter has reached zero.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    taps_nxt   = taps;
    e_nxt      = e;
    strobe_nxt = 1'b0;
    capture    = 1'b0;
    sum        = '0;
    avg        = '0;
    m          = '0;
    d          = '0;

    if (ena) begin
      case (state)
        IDLE: begin
          state_nxt = PRIME;
        end
        PRIME: begin
          state_nxt = RUN;
          // Fill every tap so the first average equals the measurement.
          taps_nxt  = {NTAP{measured}};
          capture   = 1'b1;
        end
        RUN: begin
          if (cnt == '0) begin
            taps_nxt = {taps[NTAP-2:0], measured};
            capture  = 1'b1;
          end else begin
            cnt_nxt = cnt - W'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end

    if (capture) begin
      // Average over the post-shift taps, so it includes this sample.
      sum = SUMW'(taps_nxt[0]) + SUMW'(taps_nxt[1])
          + SUMW'(taps_nxt[2]) + SUMW'(taps_nxt[3]);
      avg = W'(sum >> 2);
      m   = filt_en ? avg : measured;
      d   = $signed({1'b0, setpoint}) - $signed({1'b0, m});

      if (d > DW'(31))
        e_nxt = 6'b011111;
      else if (d < -DW'(32))
        e_nxt = 6'b100000;
      else
        e_nxt = d[W-1:0];

      strobe_nxt = 1'b1;
      cnt_nxt    = period;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      taps          <= '0;
      e             <= '0;
      sample_strobe <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      taps          <= taps_nxt;
      e             <= e_nxt;
      sample_strobe <= strobe_nxt;
    end
  end

endmodule

// File: tb/tb_error_sampler.sv
// tb_error_sampler: directed-vector bench for error_sampler covering
// priming latency, hold spacing, saturation, filtering, enable freeze,
// period reload timing and asynchronous reset.
`timescale 1ns/1ps

module tb_error_sampler;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [5:0] setpoint;
  logic [5:0] measured;
  logic       filt_en;
  logic [5:0] period;
  logic [5:0] e;
  logic       sample_strobe;

  int n_checks;
  int n_errors;

  error_sampler dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ena           (ena),
    .setpoint      (setpoint),
    .measured      (measured),
    .filt_en       (filt_en),
    .period        (period),
    .e             (e),
    .sample_strobe (sample_strobe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 6-bit two's-complement encoding of a signed expected value.
  function automatic int enc6(input int v);
    logic [5:0] t;
    t = 6'(v);
    return int'(t);
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // n edges with no capture: strobe low, e unchanged.
  task automatic hold(input int n, input int exp_e, input string tag);
    for (int i = 0; i < n; i++) begin
      step();
      check({tag, "_strb"}, int'(sample_strobe), 0);
      check({tag, "_e"}, int'(e), enc6(exp_e));
    end
  endtask

  // One edge that must capture a new e.
  task automatic cap(input int exp_e, input string tag);
    step();
    check({tag, "_strb"}, int'(sample_strobe), 1);
    check({tag, "_e"}, int'(e), enc6(exp_e));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    ena      = 1'b0;
    setpoint = '0;
    measured = '0;
    filt_en  = 1'b0;
    period   = '0;

    step();
    step();
    check("rst_e", int'(e), 0);
    check("rst_strb", int'(sample_strobe), 0);

    // Priming latency and hold spacing of 4 with period=3.
    rst_n = 1'b1; ena = 1'b1; period = 6'd3; setpoint = 6'd20; measured = 6'd12;
    hold(1, 0, "idle");
    cap(8, "prime");
    measured = 6'd2;
    hold(3, 8, "hold4");
    cap(18, "cap2");

    // Saturation, period=0 takes effect at the next reload.
    period = 6'd0; setpoint = 6'd63; measured = 6'd0;
    hold(3, 18, "hold4b");
    cap(31, "sat_pos");
    setpoint = 6'd0; measured = 6'd63;
    cap(-32, "sat_neg");
    setpoint = 6'd40; measured = 6'd40;
    cap(0, "zero");
    setpoint = 6'd30; measured = 6'd13;
    cap(17, "e17");

    // Asynchronous reset between edges.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_e", int'(e), 0);
    check("arst_strb", int'(sample_strobe), 0);
    step();
    check("arst_hold_e", int'(e), 0);
    rst_n = 1'b1; period = 6'd3; setpoint = 6'd20; measured = 6'd12;
    hold(1, 0, "re_idle");
    cap(8, "re_prime");
    hold(3, 8, "re_hold");
    cap(8, "re_cap2");

    // Moving-average filter with capture every cycle.
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; filt_en = 1'b1; setpoint = 6'd0; period = 6'd0; measured = 6'd8;
    hold(1, 0, "f_idle");
    cap(-8, "f_prime");
    measured = 6'd16;
    cap(-10, "f_avg10");
    cap(-12, "f_avg12");
    cap(-14, "f_avg14");
    cap(-16, "f_avg16");

    // Enable freeze at counter=2.
    filt_en = 1'b0; setpoint = 6'd20; measured = 6'd5; period = 6'd5;
    cap(15, "fz_cap");
    hold(3, 15, "fz_pre");
    ena = 1'b0; measured = 6'd10;
    hold(7, 15, "fz_off");
    ena = 1'b1;
    hold(2, 15, "fz_post");
    cap(10, "fz_cap2");

    // Period change mid-hold only applies at the next reload.
    measured = 6'd1;
    hold(2, 10, "pc_a");
    period = 6'd1;
    hold(3, 10, "pc_b");
    cap(19, "pc_cap1");
    measured = 6'd4;
    hold(1, 19, "pc_h2");
    cap(16, "pc_cap2");
    measured = 6'd6;
    hold(1, 16, "pc_h3");
    cap(14, "pc_cap3");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
